// File: rtl/mux_if.sv
// Signal bundle between the counter/register datapath and the output-select mux.
interface mux_if #(
  parameter int unsigned WIDTH = 8
);
  logic             counter_carry;
  logic [WIDTH-1:0] counter_value;
  logic [WIDTH-1:0] register_2_msb;
  logic [WIDTH-1:0] register_2_lsb;
  logic [2:0]       sel;
  logic [WIDTH-1:0] data_out;
  logic             sel_err;

  // Datapath side: drives the sources and select, reads the registered result.
  modport master (
    output counter_carry,
    output counter_value,
    output register_2_msb,
    output register_2_lsb,
    output sel,
    input  data_out,
    input  sel_err
  );

  // Mux side.
  modport slave (
    input  counter_carry,
    input  counter_value,
    input  register_2_msb,
    input  register_2_lsb,
    input  sel,
    output data_out,
    output sel_err
  );
endinterface

// File: rtl/mux.sv
// Registered 4:1 output-select mux for the counter/register datapath.
// Reserved select codes produce zero data and raise sel_err for that cycle.
module mux #(
  parameter int unsigned WIDTH = 8
) (
  input logic   clk,
  input logic   rst_n,
  mux_if.slave  bus
);

  localparam logic [2:0] MuxSelCounterCarry  = 3'd0;
  localparam logic [2:0] MuxSelCounterValue  = 3'd1;
  localparam logic [2:0] MuxSelRegister2Msb  = 3'd2;
  localparam logic [2:0] MuxSelRegister2Lsb  = 3'd3;

  logic [WIDTH-1:0] data_d, data_q;
  logic             err_d, err_q;

  // Decode the select against the sources sampled this cycle.
  always_comb begin
    data_d = '0;
    err_d  = 1'b0;
    case (bus.sel)
      MuxSelCounterCarry: data_d = {{(WIDTH-1){1'b0}}, bus.counter_carry};
      MuxSelCounterValue: data_d = bus.counter_value;
      MuxSelRegister2Msb: data_d = bus.register_2_msb;
      MuxSelRegister2Lsb: data_d = bus.register_2_lsb;
      default:            err_d  = 1'b1;
    endcase
  end

  // Output register; async reset clears both outputs immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  assign bus.data_out = data_q;
  assign bus.sel_err  = err_q;

endmodule

// File: tb/tb_mux.sv
// Self-checking bench for mux: expected results are queued when stimulus is
// driven and compared once the registered output is available.
module tb_mux;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst_n;

  mux_if #(.WIDTH(WIDTH)) bus ();

  mux #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      tag;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of the select decode.
  function automatic exp_t model(input string tag, input logic [2:0] s, input logic c,
                                 input logic [7:0] cv, input logic [7:0] msb,
                                 input logic [7:0] lsb);
    exp_t e;
    e.tag  = tag;
    e.err  = 1'b0;
    e.data = 8'h00;
    if (s == 3'd0)      e.data = {7'b0, c};
    else if (s == 3'd1) e.data = cv;
    else if (s == 3'd2) e.data = msb;
    else if (s == 3'd3) e.data = lsb;
    else                e.err  = 1'b1;
    return e;
  endfunction

  // Drive one vector away from the edge, queue its expectation, then check after the edge.
  task automatic apply(input string tag, input logic [2:0] s, input logic c,
                       input logic [7:0] cv, input logic [7:0] msb, input logic [7:0] lsb);
    exp_t e;
    @(negedge clk);
    bus.sel            = s;
    bus.counter_carry  = c;
    bus.counter_value  = cv;
    bus.register_2_msb = msb;
    bus.register_2_lsb = lsb;
    exp_q.push_back(model(tag, s, c, cv, msb, lsb));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val({e.tag, ".data"}, bus.data_out, e.data);
    check_val({e.tag, ".err"}, {7'b0, bus.sel_err}, {7'b0, e.err});
  endtask

  initial begin
    rst_n              = 1'b1;
    bus.sel            = 3'd5;
    bus.counter_carry  = 1'b1;
    bus.counter_value  = 8'h33;
    bus.register_2_msb = 8'h44;
    bus.register_2_lsb = 8'h55;
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_now.data", bus.data_out, 8'h00);
    check_val("rst_now.err", {7'b0, bus.sel_err}, 8'h00);
    // Outputs must hold through clock edges while reset is low.
    @(posedge clk);
    #1;
    check_val("rst_hold.data", bus.data_out, 8'h00);
    check_val("rst_hold.err", {7'b0, bus.sel_err}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    apply("post_rst", 3'd1, 1'b1, 8'h33, 8'h44, 8'h55);

    // Carry path, zero-extended.
    apply("carry1", 3'd0, 1'b1, 8'hAA, 8'hBE, 8'hEF);
    apply("carry0", 3'd0, 1'b0, 8'hAA, 8'hBE, 8'hEF);

    // Source walk.
    apply("sel1", 3'd1, 1'b0, 8'hAA, 8'hBE, 8'hEF);
    apply("sel2", 3'd2, 1'b0, 8'hAA, 8'hBE, 8'hEF);
    apply("sel3", 3'd3, 1'b0, 8'hAA, 8'hBE, 8'hEF);

    // Reserved codes.
    for (int s = 4; s < 8; s++) apply($sformatf("rsv%0d", s), 3'(s), 1'b1, 8'hAA, 8'hBE, 8'hEF);
    apply("rsv_exit", 3'd1, 1'b1, 8'hAA, 8'hBE, 8'hEF);

    // Isolation: unselected sources toggle, selected one changes last.
    apply("iso0", 3'd2, 1'b0, 8'hAA, 8'hBE, 8'hEF);
    apply("iso1", 3'd2, 1'b1, 8'h11, 8'hBE, 8'h22);
    apply("iso2", 3'd2, 1'b0, 8'hFF, 8'hBE, 8'h00);
    apply("iso_msb", 3'd2, 1'b0, 8'hFF, 8'h5A, 8'h00);

    // Sel and data change on the same edge.
    apply("swap", 3'd3, 1'b1, 8'h01, 8'h02, 8'hEF);

    // Mid-operation reset between edges.
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst.data", bus.data_out, 8'h00);
    check_val("mid_rst.err", {7'b0, bus.sel_err}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    apply("mid_rel", 3'd3, 1'b1, 8'h01, 8'h02, 8'hEF);

    // Randomised vectors.
    for (int i = 0; i < 40; i++) begin
      apply($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), 1'($urandom),
            8'($urandom), 8'($urandom), 8'($urandom));
    end

    check_val("sb_empty", 8'(exp_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #100000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
